// File: rtl/encoder_4to2_neg_in_eneable_pkg.sv
// Shared types, code constants and priority helpers for the active-low
// 4-to-2 request encoder.
package encoder_4to2_neg_in_eneable_pkg;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   // Line-to-code mapping matches the 2-to-4 active-low decoder.
   localparam logic [1:0] CODE_0 = 2'b00;
   localparam logic [1:0] CODE_1 = 2'b01;
   localparam logic [1:0] CODE_2 = 2'b10;
   localparam logic [1:0] CODE_3 = 2'b11;

   // Level of a request line when nothing is asserted.
   localparam logic REQ_IDLE = 1'b1;

   // Lowest set index wins (line 0 has highest priority).
   function automatic logic [1:0] lowest_index(input logic [3:0] req);
      logic [1:0] idx;
      idx = CODE_0;
      if (req[0]) begin
         idx = CODE_0;
      end else if (req[1]) begin
         idx = CODE_1;
      end else if (req[2]) begin
         idx = CODE_2;
      end else if (req[3]) begin
         idx = CODE_3;
      end else begin
         idx = CODE_0;
      end
      return idx;
   endfunction

   // True when two or more request bits are set.
   function automatic logic more_than_one(input logic [3:0] req);
      return ((req & (req - 4'd1)) != 4'd0);
   endfunction

endpackage

// File: rtl/encoder_4to2_neg_in_eneable_sync_edge_neg.sv
// Per-line synchroniser with falling-edge detection. All flops reset to the
// idle (high) level so that leaving reset never looks like a falling edge.
module sync_edge_neg
   import encoder_4to2_neg_in_eneable_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic rn,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   // Shift the asynchronous line through the synchroniser and keep one
   // extra delayed copy of the synchronised value for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync_r <= {SYNC_STAGES{REQ_IDLE}};
         prev_r <= REQ_IDLE;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], rn};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign fall = prev_r & ~sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/encoder_4to2_neg_in_eneable.sv
// Active-low 4-to-2 request encoder: synchronised falling edges on Rn are
// latched as pending and handed out one at a time (line 0 first) over a
// Valid/Ack handshake. All outputs come straight from flops.
module encoder_4to2_neg_in_eneable
   import encoder_4to2_neg_in_eneable_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       Clk,
   input  logic       Rstn,
   input  logic [3:0] Rn,
   input  logic       Eneable,
   input  logic       Ack,
   output logic [1:0] A,
   output logic       Valid,
   output logic       Multi,
   output logic       Overrun
);

   logic [3:0] fall_s;
   logic [3:0] captured_s;
   logic [3:0] clear_s;
   logic [3:0] pending_r;
   logic [3:0] pending_nxt_s;
   logic       overrun_nxt_s;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [1:0] a_r;
   logic [1:0] a_nxt_s;
   logic       valid_r;
   logic       valid_nxt_s;
   logic       multi_r;
   logic       multi_nxt_s;
   logic       overrun_r;

   for (genvar i = 0; i < 4; i++) begin : g_line
      sync_edge_neg #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
         .clk (Clk),
         .rstn(Rstn),
         .rn  (Rn[i]),
         .fall(fall_s[i])
      );
   end

   // Pending set/clear: new captures win over the acknowledge clear, and a
   // capture onto a still-owned pending bit is reported as an overrun.
   always_comb begin
      captured_s    = 4'b0000;
      clear_s       = 4'b0000;
      if (Eneable) begin
         captured_s = fall_s;
      end else begin
         captured_s = 4'b0000;
      end
      if ((state_r == PRESENT) && Ack) begin
         clear_s = 4'b0001 << a_r;
      end else begin
         clear_s = 4'b0000;
      end
      pending_nxt_s = (pending_r & ~clear_s) | captured_s;
      overrun_nxt_s = |(captured_s & pending_r & ~clear_s);
   end

   // Handshake FSM next state: grant from IDLE, hold while PRESENT until Ack.
   always_comb begin
      state_nxt_s = state_r;
      a_nxt_s     = a_r;
      valid_nxt_s = valid_r;
      multi_nxt_s = multi_r;
      case (state_r)
         IDLE: begin
            if (pending_r != 4'b0000) begin
               a_nxt_s     = lowest_index(pending_r);
               multi_nxt_s = more_than_one(pending_r);
               valid_nxt_s = 1'b1;
               state_nxt_s = PRESENT;
            end else begin
               valid_nxt_s = 1'b0;
               state_nxt_s = IDLE;
            end
         end
         PRESENT: begin
            if (Ack) begin
               valid_nxt_s = 1'b0;
               state_nxt_s = IDLE;
            end else begin
               valid_nxt_s = 1'b1;
               state_nxt_s = PRESENT;
            end
         end
         default: begin
            valid_nxt_s = 1'b0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, pending and output registers.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         state_r   <= IDLE;
         pending_r <= 4'b0000;
         a_r       <= CODE_0;
         valid_r   <= 1'b0;
         multi_r   <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         pending_r <= pending_nxt_s;
         a_r       <= a_nxt_s;
         valid_r   <= valid_nxt_s;
         multi_r   <= multi_nxt_s;
         overrun_r <= overrun_nxt_s;
      end
   end

   assign A       = a_r;
   assign Valid   = valid_r;
   assign Multi   = multi_r;
   assign Overrun = overrun_r;

endmodule

// File: tb/tb_encoder_4to2_neg_in_eneable.sv
// Randomised and directed stimulus against an event-level reference model;
// expected per-cycle responses are queued and popped by a separate monitor.
module tb_encoder_4to2_neg_in_eneable;

   localparam int SYNC = 2;

   logic       Clk = 1'b0;
   logic       Rstn;
   logic [3:0] Rn;
   logic       Eneable;
   logic       Ack;
   logic [1:0] A;
   logic       Valid;
   logic       Multi;
   logic       Overrun;

   encoder_4to2_neg_in_eneable #(.SYNC_STAGES(SYNC)) dut (
      .Clk    (Clk),
      .Rstn   (Rstn),
      .Rn     (Rn),
      .Eneable(Eneable),
      .Ack    (Ack),
      .A      (A),
      .Valid  (Valid),
      .Multi  (Multi),
      .Overrun(Overrun)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic       valid;
      logic [1:0] a;
      logic       multi;
      logic       overrun;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   logic [3:0] hist[$];
   logic [3:0] m_pending;
   bit         m_present;
   int         m_idx;
   bit         m_multi;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int j = 0; j <= SYNC; j++) hist.push_back(4'hF);
      m_pending = 4'b0000;
      m_present = 0;
      m_idx     = 0;
      m_multi   = 0;
      exp_q.delete();
   endtask

   // Reference model: a line requests when its synchronised view goes from
   // high to low; requests are a set of pending lines served lowest first.
   initial begin
      model_reset();
      forever begin : model_step
         logic [3:0] fall;
         logic [3:0] cap;
         logic [3:0] oldp;
         int         cleared;
         int         cnt;
         int         lo;
         bit         ovr;
         exp_t       e;
         @(posedge Clk or negedge Rstn);
         if (!Rstn) begin
            model_reset();
         end else begin
            for (int i = 0; i < 4; i++)
               fall[i] = (hist[SYNC][i] == 1'b1) && (hist[SYNC-1][i] == 1'b0);
            cap     = Eneable ? fall : 4'b0000;
            cleared = (m_present && Ack) ? m_idx : -1;
            ovr     = 0;
            for (int i = 0; i < 4; i++)
               if (cap[i] && m_pending[i] && (i != cleared)) ovr = 1;
            oldp = m_pending;
            if (!m_present && (oldp != 4'b0000)) begin
               cnt = 0;
               lo  = 0;
               for (int i = 3; i >= 0; i--)
                  if (oldp[i]) begin
                     lo = i;
                     cnt++;
                  end
               m_idx     = lo;
               m_multi   = (cnt > 1);
               m_present = 1;
            end else if (m_present && Ack) begin
               m_present = 0;
            end
            if (cleared >= 0) m_pending[cleared] = 1'b0;
            m_pending = m_pending | cap;
            e.valid   = m_present;
            e.a       = 2'(m_idx);
            e.multi   = m_multi;
            e.overrun = ovr;
            exp_q.push_back(e);
            hist.push_front(Rn);
            void'(hist.pop_back());
         end
      end
   end

   // Monitor: pops the expected response of each cycle and compares.
   initial begin
      forever begin : monitor_step
         exp_t e;
         @(negedge Clk);
         if (!Rstn) begin
            check("reset_valid", Valid, 1'b0);
            check("reset_a", A, 2'b00);
            check("reset_multi", Multi, 1'b0);
            check("reset_overrun", Overrun, 1'b0);
         end else if (exp_q.size() == 0) begin
            check("queue_nonempty", 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("valid", Valid, e.valid);
            check("a", A, e.a);
            check("multi", Multi, e.multi);
            check("overrun", Overrun, e.overrun);
         end
      end
   end

   task automatic step(input logic [3:0] rn, input logic en, input logic ack, input int n);
      repeat (n) begin
         @(negedge Clk);
         #1;
         Rn      = rn;
         Eneable = en;
         Ack     = ack;
      end
   endtask

   task automatic set_rst(input logic v);
      @(negedge Clk);
      #1;
      Rstn = v;
   endtask

   initial begin
      logic [3:0] r;
      Rstn = 1'b0; Rn = 4'hF; Eneable = 1'b1; Ack = 1'b0;
      step(4'hF, 1'b1, 1'b0, 3);
      set_rst(1'b1);
      // idle after reset: no spurious events
      step(4'hF, 1'b1, 1'b0, 10);
      // single line, held low, then acknowledged
      step(4'b1011, 1'b1, 1'b0, 8);
      step(4'b1011, 1'b1, 1'b1, 1);
      step(4'b1011, 1'b1, 1'b0, 6);
      step(4'hF, 1'b1, 1'b0, 4);
      // two lines at once, Ack held high
      step(4'b0110, 1'b1, 1'b1, 10);
      step(4'hF, 1'b1, 1'b1, 4);
      // edge while disabled is dropped; a later edge is served
      step(4'b1101, 1'b0, 1'b0, 4);
      step(4'b1101, 1'b1, 1'b0, 5);
      step(4'hF, 1'b1, 1'b0, 3);
      step(4'b1101, 1'b1, 1'b0, 6);
      step(4'b1101, 1'b1, 1'b1, 1);
      step(4'hF, 1'b1, 1'b0, 4);
      // double pulse on line 2 without Ack: one overrun, one grant
      step(4'b1011, 1'b1, 1'b0, 3);
      step(4'hF, 1'b1, 1'b0, 3);
      step(4'b1011, 1'b1, 1'b0, 3);
      step(4'hF, 1'b1, 1'b0, 4);
      step(4'hF, 1'b1, 1'b1, 1);
      step(4'hF, 1'b1, 1'b0, 6);
      // reset while presenting with two lines pending
      step(4'b1010, 1'b1, 1'b0, 5);
      set_rst(1'b0);
      step(4'hF, 1'b1, 1'b0, 2);
      set_rst(1'b1);
      step(4'hF, 1'b1, 1'b0, 8);
      // randomised phase: slowly toggling lines, random enable and Ack
      r = 4'hF;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         step(r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1), 1);
      end
      step(4'hF, 1'b1, 1'b1, 8);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder_4to2_neg_in_eneable.md
Name: encoder_4to2_neg_in_eneable

Overview:
- Encoding counterpart of the 2-to-4 active-low decoder with enable: collects events on four active-low request lines and returns them one at a time as a 2-bit index.
- Request lines are synchronised, falling-edge detected, latched as pending, priority-encoded (line 0 highest) and presented with a Valid/Ack handshake.
- Sits between external active-low select/interrupt lines and the control logic that consumes a binary code.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per request line (legal range 2..4).

Ports:
- Clk  input  1  rising-edge clock.
- Rstn  input  1  asynchronous active-low reset.
- Rn  input  4  active-low request lines, asynchronous to Clk; idle level is 1.
- Eneable  input  1  active-high capture enable.
- Ack  input  1  consumer acknowledge of the presented code.
- A  output  2  encoded index of the presented line.
- Valid  output  1  A holds a valid code.
- Multi  output  1  other requests were still pending when A was granted.
- Overrun  output  1  one-cycle pulse: an edge arrived on a line that was already pending.

Behaviour:
- Reset (async assert, sync release):
  - A=2'b00, Valid=0, Multi=0, Overrun=0.
  - pending=4'b0000, state=IDLE.
  - All synchroniser and previous-value flops reset to 1, so release of reset never creates a false edge.
- Synchroniser: each Rn bit passes through SYNC_STAGES flops. Define s[i] as the last-stage output and p[i] as s[i] delayed by one flop.
- Edge detect: fall[i] = p[i] & ~s[i]. Only falling edges generate requests; a held-low level produces exactly one event.
- Capture:
  - If Eneable=1 and fall[i]=1, set pending[i] on the next edge.
  - If Eneable=0, edges are discarded, but existing pending bits and any in-progress handshake are retained.
- Overrun: a captured fall[i] while pending[i] is already 1 pulses Overrun for one cycle. The events merge; no count is kept.
- FSM, two states:
  - IDLE: Valid=0. If pending!=0, then on the next edge:
    - A = lowest set index of pending.
    - Multi = 1 if more than one pending bit is set.
    - Valid=1; go to PRESENT.
  - IDLE ignores Eneable; pending bits present are always served.
  - PRESENT: A, Multi and Valid are held stable regardless of Rn and Eneable. On an edge with Ack=1: clear pending[A], Valid=0, go to IDLE.
- Ack in IDLE has no effect.
- Throughput: at most one code per 2 cycles; IDLE always lasts at least one cycle between grants.
- Simultaneous set and clear on the same bit (new fall captured on the edge that acknowledges it): set wins, so pending stays 1 and is served again. Overrun does not pulse, because the bit was being consumed.
- Latency: count the first edge that samples Rn[i]=0 as edge 1.
  - s[i] falls after edge SYNC_STAGES.
  - pending[i] is set at edge SYNC_STAGES+1.
  - Valid rises at edge SYNC_STAGES+2 (edge 4 for the default).
- Reset asserted mid-operation immediately returns everything to reset values; pending events are lost.
- Outputs are all registered; no combinational path from any input to any output.

Decomposition:
- Shared package:
  - state typedef (IDLE, PRESENT).
  - Constants for codes 2'b00..2'b11, matching the decoder's line mapping.
  - REQ_IDLE = 1'b1 (idle level).
- Sub-module sync_edge_neg (one instance per line, SYNC_STAGES parameter): synchroniser plus previous-value flop, outputs fall. Its flops reset to 1.
- Capture, priority encode and FSM stay in the top module.

Test Plan:
- Reset release with Rn=4'b1111 and Eneable=1 -> A=00, Valid=0, Overrun=0 for 10 cycles; no spurious event.
- Rn=4'b1011 held from edge 1, Eneable=1, Ack=0 -> Valid=1 with A=2'b10, Multi=0 at edge 4. Both stay stable until Ack=1, then Valid=0 on the next edge; no re-grant while Rn stays low.
- Rn 4'b1111->4'b0110 in one cycle, Ack held 1 -> grants A=00 (Multi=1), then A=11 (Multi=0), with Valid low for one cycle between them.
- Eneable=0 while Rn[1] falls, then Eneable=1 with Rn held low -> no grant, Valid stays 0. A second fall of Rn[1] with Eneable=1 -> A=01.
- Rn[2] pulses low twice (3 cycles low, 3 cycles high, 3 cycles low) with no Ack -> exactly one Overrun pulse. After Ack, a single grant with A=10 and no further grant.
- Rstn asserted while in PRESENT with pending=4'b0101 -> Valid, A, Multi and pending go to 0 immediately. After release with Rn=4'b1111 -> no grants.
